lupa_spi_cfg: RTL and testbench

LUPA_SPI_CFG -- requirements
Module: lupa_spi_cfg

---
 rtl/lupa_spi_cfg.sv | 222 ++++++++++++++++++++++
 tb/tb_lupa_spi_cfg.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lupa_spi_cfg.sv
// Configuration table and SPI frame sequencer for the LUPA sensor.
// Sends {addr, data} frames MSB first; in verify mode it reads the data back and compares it.
module lupa_spi_cfg #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic                         clock_40,
    input  logic                         reset,
    input  logic                         tbl_we,
    input  logic [$clog2(DEPTH)-1:0]     tbl_waddr,
    input  logic [ADDR_W+DATA_W-1:0]     tbl_wdata,
    input  logic                         start,
    input  logic [$clog2(DEPTH):0]       nrg,
    input  logic                         verify,
    input  logic                         spi_miso,
    output logic                         spi_clk,
    output logic                         spi_en,
    output logic                         spi_dat,
    output logic                         busy,
    output logic                         cfg_DONE,
    output logic                         cfg_ERR,
    output logic [$clog2(DEPTH)-1:0]     err_idx
);

    localparam int unsigned FW = ADDR_W + DATA_W;
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned NW = IW + 1;
    localparam int unsigned CW = 9;
    localparam int unsigned BW = $clog2(FW + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [NW-1:0]   nrg_q, nrg_d;
    logic            vfy_q, vfy_d;
    logic [FW-1:0]   sreg_q, sreg_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic [FW-1:0]   tbl_q [DEPTH];
    logic [FW-1:0]   tbl_d [DEPTH];
    logic            spi_clk_q, spi_clk_d;
    logic            spi_en_q, spi_en_d;
    logic            spi_dat_q, spi_dat_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [IW-1:0]   err_idx_q, err_idx_d;

    logic [FW-1:0]   entry;
    logic            more;
    logic            cnt_zero;

    // Next-state, table write and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        idx_d     = idx_q;
        nrg_d     = nrg_q;
        vfy_d     = vfy_q;
        sreg_d    = sreg_q;
        cap_d     = cap_q;
        tbl_d     = tbl_q;
        spi_clk_d = spi_clk_q;
        spi_en_d  = spi_en_q;
        spi_dat_d = spi_dat_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;

        entry    = tbl_q[idx_q];
        more     = (32'(idx_q) + 32'd1) < 32'(nrg_q);
        cnt_zero = (cnt_q == '0);

        if (!cnt_zero) cnt_d = cnt_q - CW'(1);

        if ((state_q == IDLE || state_q == DONE) && tbl_we && 32'(tbl_waddr) < DEPTH)
            tbl_d[tbl_waddr] = tbl_wdata;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    nrg_d     = (32'(nrg) > DEPTH) ? NW'(DEPTH) : nrg;
                    vfy_d     = verify;
                    err_d     = 1'b0;
                    err_idx_d = '0;
                    idx_d     = '0;
                    if (nrg == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = LOAD;
                        done_d  = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
            end
            LOAD: begin
                sreg_d    = vfy_q ? {entry[FW-1 -: ADDR_W], DATA_W'(0)} : entry;
                spi_en_d  = 1'b0;
                spi_clk_d = 1'b0;
                spi_dat_d = sreg_d[FW-1];
                cnt_d     = CW'(CLK_DIV - 1);
                bit_d     = '0;
                state_d   = SETUP;
            end
            SETUP: begin
                if (cnt_zero) begin
                    spi_clk_d = 1'b1;
                    cnt_d     = CW'(CLK_DIV - 1);
                    state_d   = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (cnt_zero) begin
                    // Readback is sampled at the very end of the high phase of each data bit.
                    if (vfy_q && 32'(bit_q) >= ADDR_W)
                        cap_d = DATA_W'({cap_q, spi_miso});
                    sreg_d    = sreg_q << 1;
                    spi_dat_d = sreg_q[FW-2];
                    spi_clk_d = 1'b0;
                    cnt_d     = CW'(CLK_DIV - 1);
                    state_d   = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (cnt_zero) begin
                    cnt_d = CW'(CLK_DIV - 1);
                    if (32'(bit_q) == FW - 1) begin
                        state_d = HOLD;
                    end else begin
                        bit_d     = bit_q + BW'(1);
                        spi_clk_d = 1'b1;
                        state_d   = SHIFT_HI;
                    end
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    if (vfy_q && !err_q && cap_q != entry[DATA_W-1:0]) begin
                        err_d     = 1'b1;
                        err_idx_d = idx_q;
                    end
                    spi_en_d  = 1'b1;
                    spi_dat_d = 1'b0;
                    // LOAD takes the final cycle of an inter-frame gap.
                    cnt_d     = more ? CW'(2 * CLK_DIV - 2) : CW'(2 * CLK_DIV - 1);
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    if (more) begin
                        idx_d   = idx_q + IW'(1);
                        state_d = LOAD;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any frame on the spot.
    always_ff @(posedge clock_40 or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            idx_q     <= '0;
            nrg_q     <= '0;
            vfy_q     <= 1'b0;
            sreg_q    <= '0;
            cap_q     <= '0;
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
            spi_clk_q <= 1'b0;
            spi_en_q  <= 1'b1;
            spi_dat_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            idx_q     <= idx_d;
            nrg_q     <= nrg_d;
            vfy_q     <= vfy_d;
            sreg_q    <= sreg_d;
            cap_q     <= cap_d;
            tbl_q     <= tbl_d;
            spi_clk_q <= spi_clk_d;
            spi_en_q  <= spi_en_d;
            spi_dat_q <= spi_dat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign spi_clk  = spi_clk_q;
    assign spi_en   = spi_en_q;
    assign spi_dat  = spi_dat_q;
    assign busy     = busy_q;
    assign cfg_DONE = done_q;
    assign cfg_ERR  = err_q;
    assign err_idx  = err_idx_q;

endmodule

// File: tb/tb_lupa_spi_cfg.sv
// Self-checking bench for lupa_spi_cfg: expected frames are queued at start and
// compared as the SPI monitor reassembles them; a sensor model answers readback.
module tb_lupa_spi_cfg;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 12;
    localparam int unsigned DEPTH = 16;

    logic        clock_40 = 1'b0;
    logic        reset = 1'b1;
    logic        tbl_we = 1'b0;
    logic [3:0]  tbl_waddr = '0;
    logic [15:0] tbl_wdata = '0;
    logic        start = 1'b0;
    logic [4:0]  nrg = '0;
    logic        verify = 1'b0;
    logic        spi_miso = 1'b0;

    logic spi_clk, spi_en, spi_dat, busy, cfg_done, cfg_err;
    logic [3:0] err_idx;
    logic spi_clk1, spi_en1, spi_dat1, busy1, cfg_done1, cfg_err1;
    logic [3:0] err_idx1;

    always #5 clock_40 = ~clock_40;

    lupa_spi_cfg #(.ADDR_W(4), .DATA_W(12), .DEPTH(16), .CLK_DIV(2)) dut (
        .clock_40(clock_40), .reset(reset), .tbl_we(tbl_we), .tbl_waddr(tbl_waddr),
        .tbl_wdata(tbl_wdata), .start(start), .nrg(nrg), .verify(verify),
        .spi_miso(spi_miso), .spi_clk(spi_clk), .spi_en(spi_en), .spi_dat(spi_dat),
        .busy(busy), .cfg_DONE(cfg_done), .cfg_ERR(cfg_err), .err_idx(err_idx)
    );

    lupa_spi_cfg #(.ADDR_W(4), .DATA_W(12), .DEPTH(16), .CLK_DIV(1)) dut1 (
        .clock_40(clock_40), .reset(reset), .tbl_we(tbl_we), .tbl_waddr(tbl_waddr),
        .tbl_wdata(tbl_wdata), .start(start), .nrg(nrg), .verify(verify),
        .spi_miso(spi_miso), .spi_clk(spi_clk1), .spi_en(spi_en1), .spi_dat(spi_dat1),
        .busy(busy1), .cfg_DONE(cfg_done1), .cfg_ERR(cfg_err1), .err_idx(err_idx1)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    logic [15:0] mdl [DEPTH];
    logic [11:0] sensor [16];
    logic [15:0] exp_q [$];

    // SPI monitor and sensor model, sampled on the falling system-clock edge.
    logic        prev_clk = 1'b0;
    logic        prev_en = 1'b1;
    int          low_cnt = 0;
    int          bitn = 0;
    int          gap = 0;
    int          frames_seen = 0;
    bit          in_gap = 1'b0;
    logic [15:0] shf = '0;
    logic [3:0]  cur_addr = '0;
    logic [11:0] sv = '0;

    always @(negedge clock_40) begin
        if (reset) begin
            low_cnt = 0;
            bitn    = 0;
            in_gap  = 1'b0;
        end else begin
            if (!spi_en && prev_en) begin
                if (in_gap) check_eq("gap_len", gap, 4);
                in_gap  = 1'b0;
                low_cnt = 0;
                bitn    = 0;
            end
            if (!spi_en) low_cnt++;
            if (spi_clk && !prev_clk && !spi_en) begin
                shf = {shf[14:0], spi_dat};
                if (bitn == AW - 1) cur_addr = shf[3:0];
                if (bitn >= AW) begin
                    sv = sensor[cur_addr];
                    spi_miso = sv[DW - 1 - (bitn - AW)];
                end
                bitn++;
            end
            if (spi_en && !prev_en) begin
                frames_seen++;
                check_eq("frame_len", low_cnt, 68);
                check_eq("frame_bits", bitn, 16);
                if (exp_q.size() == 0) check_eq("unexpected_frame", shf, 32'hFFFF_FFFF);
                else check_eq("frame_data", shf, exp_q.pop_front());
                in_gap = 1'b1;
                gap    = 0;
            end
            if (spi_en && in_gap) begin
                if (busy) gap++;
                else in_gap = 1'b0;
            end
        end
        prev_clk = spi_clk;
        prev_en  = spi_en;
    end

    // Frame length of the CLK_DIV=1 build.
    logic prev_en1 = 1'b1;
    int   low1 = 0;
    always @(negedge clock_40) begin
        if (reset) low1 = 0;
        else begin
            if (!spi_en1 && prev_en1) low1 = 0;
            if (!spi_en1) low1++;
            if (spi_en1 && !prev_en1) check_eq("frame_len_div1", low1, 34);
        end
        prev_en1 = spi_en1;
    end

    task automatic tick();
        @(posedge clock_40);
        #2;
    endtask

    task automatic wr(input int idx, input logic [15:0] v);
        tbl_we    = 1'b1;
        tbl_waddr = 4'(idx);
        tbl_wdata = v;
        mdl[idx]  = v;
        tick();
        tbl_we    = 1'b0;
    endtask

    task automatic go(input int n, input logic v);
        int m;
        nrg    = 5'(n);
        verify = v;
        start  = 1'b1;
        m = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < m; i++)
            exp_q.push_back(v ? {mdl[i][15:12], 12'h000} : mdl[i]);
        tick();
        start  = 1'b0;
        tbl_we = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic exp_err, input logic [3:0] exp_idx);
        int k = 0;
        while (!cfg_done && k < 4000) begin
            tick();
            k++;
        end
        check_eq({tag, "_done"}, cfg_done, 1);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_frames_left"}, exp_q.size(), 0);
        check_eq({tag, "_err"}, cfg_err, exp_err);
        check_eq({tag, "_err_idx"}, err_idx, exp_idx);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got no summary, expected completion");
        $fatal(1);
    end

    initial begin
        int f0;
        int k;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        for (int i = 0; i < 16; i++) sensor[i] = '0;
        tick(); tick(); tick();
        check_eq("rst_spi_en", spi_en, 1);
        check_eq("rst_spi_clk", spi_clk, 0);
        check_eq("rst_spi_dat", spi_dat, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", cfg_done, 0);
        check_eq("rst_err", {cfg_err, err_idx}, 0);
        reset = 1'b0;
        tick();

        // Single frame.
        wr(0, 16'h30A0);
        go(1, 1'b0);
        check_eq("single_busy_during", busy, 1);
        wait_done("single", 1'b0, 4'd0);

        // Full table, last entry written in the same cycle as start.
        for (int i = 0; i < 15; i++) wr(i, {4'(i), 12'($urandom_range(0, 4095))});
        tbl_we    = 1'b1;
        tbl_waddr = 4'd15;
        tbl_wdata = 16'hF5A5;
        mdl[15]   = 16'hF5A5;
        go(16, 1'b0);
        wait_done("full", 1'b0, 4'd0);

        // Oversized count clamps to the table depth.
        f0 = frames_seen;
        go(20, 1'b0);
        wait_done("clamp", 1'b0, 4'd0);
        check_eq("clamp_frames", frames_seen - f0, 16);

        // Readback: entry 1 mismatches.
        for (int i = 0; i < 16; i++) sensor[i] = mdl[i][11:0];
        sensor[1] = 12'hFFF;
        go(3, 1'b1);
        wait_done("verify1", 1'b1, 4'd1);

        // Readback: entries 0 and 2 mismatch, only the first is reported.
        sensor[1] = mdl[1][11:0];
        sensor[0] = ~mdl[0][11:0];
        sensor[2] = ~mdl[2][11:0];
        go(3, 1'b1);
        wait_done("verify2", 1'b1, 4'd0);

        // Clean readback clears the previous error.
        sensor[0] = mdl[0][11:0];
        sensor[2] = mdl[2][11:0];
        go(3, 1'b1);
        wait_done("verify3", 1'b0, 4'd0);

        // Zero count: done on the next cycle, no frame, error cleared.
        sensor[0] = ~mdl[0][11:0];
        go(1, 1'b1);
        wait_done("pre_zero", 1'b1, 4'd0);
        f0 = frames_seen;
        go(0, 1'b0);
        check_eq("zero_done", cfg_done, 1);
        check_eq("zero_err", cfg_err, 0);
        for (int i = 0; i < 10; i++) tick();
        check_eq("zero_no_frame", frames_seen - f0, 0);
        check_eq("zero_spi_en", spi_en, 1);

        // Start and table write while busy are ignored.
        go(2, 1'b0);
        for (int i = 0; i < 30; i++) tick();
        check_eq("busy_mid_run", busy, 1);
        tbl_we    = 1'b1;
        tbl_waddr = 4'd0;
        tbl_wdata = 16'hDEAD;
        nrg       = 5'd5;
        start     = 1'b1;
        tick();
        tbl_we = 1'b0;
        start  = 1'b0;
        wait_done("ignored", 1'b0, 4'd0);
        go(1, 1'b0);
        wait_done("old_entry", 1'b0, 4'd0);

        // Reset in the middle of frame 2.
        f0 = frames_seen;
        go(3, 1'b0);
        k = 0;
        while (!(frames_seen == f0 + 1 && low_cnt == 20) && k < 2000) begin
            tick();
            k++;
        end
        check_eq("abort_reached", (k < 2000), 1);
        reset = 1'b1;
        #1;
        check_eq("abort_spi_en", spi_en, 1);
        check_eq("abort_busy", busy, 0);
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        tick(); tick();
        check_eq("abort_done", cfg_done, 0);
        reset = 1'b0;
        tick();
        go(1, 1'b0);
        wait_done("cleared", 1'b0, 4'd0);
        wr(0, 16'h1234);
        wr(1, 16'h2ABC);
        f0 = frames_seen;
        go(2, 1'b0);
        wait_done("restart", 1'b0, 4'd0);
        check_eq("restart_frames", frames_seen - f0, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
